row_pivot_div_seq: RTL and testbench

//  Row-normalisation sequencer for the linear-equation solver. Takes one matrix row
//  (stream of fp16 elements) and the row's pivot, and issues element/pivot pairs to

---
 rtl/row_pivot_div_seq.sv | 194 +++++++++++++++++++
 tb/tb_row_pivot_div_seq.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_pivot_div_seq.sv
// row_pivot_div_seq: issues element/pivot pairs from one matrix row to a
// fixed-latency fp16 divider and returns the quotients in order, tagged with
// element index, last flag and done/err status.
module row_pivot_div_seq #(
    parameter int unsigned DIV_LAT = 6,
    parameter int unsigned LEN_W   = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      pivot,
    input  logic [LEN_W-1:0] row_len,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    output logic [15:0]      div_adata,
    output logic [15:0]      div_bdata,
    input  logic [15:0]      div_cdata,
    output logic             out_valid,
    output logic [15:0]      out_data,
    output logic [LEN_W-1:0] out_index,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Row context latched on an honoured start
    logic [15:0]      pivot_q,   pivot_d;
    logic [LEN_W-1:0] len_q,     len_d;
    logic             err_q,     err_d;

    // Issue and result counters
    logic [LEN_W-1:0] iss_cnt_q, iss_cnt_d;
    logic [LEN_W-1:0] res_cnt_q, res_cnt_d;

    // One token per accepted element, aligned with the divider latency
    logic [DIV_LAT:0] vld_q,     vld_d;

    // Divider operand registers
    logic [15:0]      adata_q,   adata_d;
    logic [15:0]      bdata_q,   bdata_d;

    // Result registers
    logic             ovalid_q,  ovalid_d;
    logic [15:0]      odata_q,   odata_d;
    logic [LEN_W-1:0] oidx_q,    oidx_d;

    logic             start_ok;
    logic             accept;
    logic             emit;
    logic             last_accept;
    logic             pipe_empty;
    logic             all_emitted;

    // Handshake and pipeline qualifiers
    always_comb begin
        start_ok    = (state_q == S_IDLE) && start;
        accept      = (state_q == S_ISSUE) && in_valid;
        emit        = vld_q[DIV_LAT];
        last_accept = accept && (iss_cnt_q == (len_q - LEN_W'(1)));
        pipe_empty  = (vld_q == '0);
        all_emitted = (res_cnt_q == len_q);
    end

    // FSM state register
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and status outputs
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = (row_len == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                in_ready = 1'b1;
                if (last_accept) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pipe_empty && all_emitted) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next-state: row latch, operand issue, token pipe, result capture
    always_comb begin
        pivot_d   = pivot_q;
        len_d     = len_q;
        err_d     = err_q;
        iss_cnt_d = iss_cnt_q;
        res_cnt_d = res_cnt_q;
        adata_d   = adata_q;
        bdata_d   = bdata_q;
        vld_d     = {vld_q[DIV_LAT-1:0], accept};
        ovalid_d  = emit;
        odata_d   = odata_q;
        oidx_d    = oidx_q;

        if (start_ok) begin
            pivot_d   = pivot;
            len_d     = row_len;
            err_d     = (pivot[14:0] == 15'h0000);
            iss_cnt_d = '0;
            res_cnt_d = '0;
        end

        if (accept) begin
            adata_d   = in_data;
            bdata_d   = pivot_q;
            iss_cnt_d = iss_cnt_q + LEN_W'(1);
        end

        // A zero pivot makes every quotient meaningless; report zeros instead
        if (emit) begin
            odata_d   = err_q ? 16'h0000 : div_cdata;
            oidx_d    = res_cnt_q;
            res_cnt_d = res_cnt_q + LEN_W'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            pivot_q   <= '0;
            len_q     <= '0;
            err_q     <= 1'b0;
            iss_cnt_q <= '0;
            res_cnt_q <= '0;
            adata_q   <= '0;
            bdata_q   <= '0;
            vld_q     <= '0;
            ovalid_q  <= 1'b0;
            odata_q   <= '0;
            oidx_q    <= '0;
        end else begin
            pivot_q   <= pivot_d;
            len_q     <= len_d;
            err_q     <= err_d;
            iss_cnt_q <= iss_cnt_d;
            res_cnt_q <= res_cnt_d;
            adata_q   <= adata_d;
            bdata_q   <= bdata_d;
            vld_q     <= vld_d;
            ovalid_q  <= ovalid_d;
            odata_q   <= odata_d;
            oidx_q    <= oidx_d;
        end
    end

    // Output mapping
    always_comb begin
        div_adata = adata_q;
        div_bdata = bdata_q;
        out_valid = ovalid_q;
        out_data  = odata_q;
        out_index = oidx_q;
        out_last  = ovalid_q && (oidx_q == (len_q - LEN_W'(1)));
        err       = err_q;
    end

endmodule

// File: tb/tb_row_pivot_div_seq.sv
// Bench for row_pivot_div_seq: fixed-latency fp16 divider model, directed
// vector table, reset and ignored-start sequences, randomized rows.
module tb_row_pivot_div_seq;

    localparam int DIV_LAT = 6;
    localparam int LEN_W   = 8;

    logic             clock = 1'b0;
    logic             rst;
    logic             start;
    logic [15:0]      pivot;
    logic [LEN_W-1:0] row_len;
    logic             in_valid;
    logic [15:0]      in_data;
    logic             in_ready;
    logic [15:0]      div_adata;
    logic [15:0]      div_bdata;
    logic [15:0]      div_cdata;
    logic             out_valid;
    logic [15:0]      out_data;
    logic [LEN_W-1:0] out_index;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             err;

    row_pivot_div_seq #(.DIV_LAT(DIV_LAT), .LEN_W(LEN_W)) dut (
        .clock     (clock),
        .rst       (rst),
        .start     (start),
        .pivot     (pivot),
        .row_len   (row_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .div_adata (div_adata),
        .div_bdata (div_bdata),
        .div_cdata (div_cdata),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // ---------------- fp16 arithmetic via reals ----------------
    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
        else        for (int i = 0; i < -e; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real h2r(input logic [15:0] h);
        real v;
        int  ex;
        ex = int'(h[14:10]);
        if (ex == 0) v = real'(int'(h[9:0])) * pow2(-24);
        else         v = (1.0 + real'(int'(h[9:0])) / 1024.0) * pow2(ex - 15);
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2h(input real v, input logic s);
        real a;
        int  e;
        int  m;
        a = (v < 0.0) ? -v : v;
        if (a == 0.0) return {s, 15'h0000};
        e = 15;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        if (e >= 31) return {s, 5'h1F, 10'h000};
        if (e <= 0)  return {s, 15'h0000};
        m = $rtoi((a - 1.0) * 1024.0);
        return {s, 5'(e), 10'(m)};
    endfunction

    function automatic logic [15:0] fdiv(input logic [15:0] a, input logic [15:0] b);
        if (b[14:0] == 15'h0000) return {a[15] ^ b[15], 5'h1F, 10'h000};
        return r2h(h2r(a) / h2r(b), a[15] ^ b[15]);
    endfunction

    function automatic logic [15:0] rnd_h();
        logic [15:0] h;
        h = {1'($urandom), 5'($urandom_range(10, 20)), 10'($urandom)};
        return h;
    endfunction

    // ---------------- float_div environment model ----------------
    // Samples a/b one edge after they are driven; quotient valid after edge E+DIV_LAT.
    logic [15:0] dpipe [DIV_LAT];
    always @(posedge clock) begin
        for (int i = DIV_LAT - 1; i > 0; i--) dpipe[i] <= dpipe[i-1];
        dpipe[0] <= fdiv(div_adata, div_bdata);
    end
    assign div_cdata = dpipe[DIV_LAT-1];

    always @(posedge clock) cyc++;

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [15:0]      d;
        logic [LEN_W-1:0] idx;
        logic             last;
        int               due;
    } exp_t;

    exp_t        sq[$];
    exp_t        me;
    logic [15:0] row_elem [256];
    logic [15:0] row_exp  [256];
    int          mdl_len  = 0;
    int          acc_cnt  = 0;
    int          emitted  = 0;
    int          last_cyc = -1;

    // Accept seen here at cycle n lands on edge n+1; its result is visible from cycle n+DIV_LAT+2.
    always @(negedge clock) begin
        if (rst) begin
            sq.delete();
        end else begin
            if (in_valid && in_ready) begin
                me.d    = row_exp[acc_cnt];
                me.idx  = LEN_W'(acc_cnt);
                me.last = (acc_cnt == mdl_len - 1);
                me.due  = cyc + DIV_LAT + 2;
                sq.push_back(me);
                acc_cnt++;
            end
            if (out_valid) begin
                if (sq.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    me = sq.pop_front();
                    chk("out_data", 32'(out_data), 32'(me.d));
                    chk("out_index", 32'(out_index), 32'(me.idx));
                    chk("out_last", 32'(out_last), 32'(me.last));
                    chk("out_latency", cyc, me.due);
                    emitted++;
                    if (me.last) last_cyc = cyc;
                end
            end else begin
                if (out_last) chk("last_without_valid", 32'(out_last), 32'd0);
                if (sq.size() != 0 && cyc > sq[0].due) begin
                    chk("result_overdue", cyc, sq[0].due);
                    void'(sq.pop_front());
                end
            end
        end
    end

    // ---------------- row driver ----------------
    task automatic run_row(input logic [15:0] pv, input int ln, input int gap,
                           input logic exp_err, input bit noise, input bit rgap);
        int t;
        int g;
        int start_cyc;
        mdl_len  = ln;
        acc_cnt  = 0;
        emitted  = 0;
        last_cyc = -1;
        start    = 1'b1;
        pivot    = pv;
        row_len  = LEN_W'(ln);
        @(posedge clock); #1;
        start     = 1'b0;
        start_cyc = cyc;
        chk("err_on_start", 32'(err), 32'(exp_err));
        chk("busy_after_start", 32'(busy), 32'd1);
        if (ln == 0) chk("in_ready_len0", 32'(in_ready), 32'd0);
        for (int k = 0; k < ln; k++) begin
            in_valid = 1'b1;
            in_data  = row_elem[k];
            if (noise) begin
                start   = 1'b1;
                pivot   = 16'h0000;
                row_len = LEN_W'(7);
            end
            t = 0;
            while (!in_ready && t < 20) begin @(posedge clock); #1; t++; end
            if (t >= 20) chk("in_ready_timeout", t, 0);
            @(posedge clock); #1;
            in_valid = 1'b0;
            start    = 1'b0;
            in_data  = 16'($urandom);
            g = rgap ? int'($urandom_range(0, 2)) : gap;
            if (k < ln - 1) repeat (g) begin @(posedge clock); #1; end
        end
        if (noise) start = 1'b1;
        t = 0;
        while (!done && t < 200) begin @(posedge clock); #1; start = 1'b0; t++; end
        start = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
        if (ln == 0) chk("done_cycle_len0", cyc, start_cyc);
        else         chk("done_after_last", cyc, last_cyc + 1);
        chk("results_emitted", emitted, ln);
        chk("err_sticky", 32'(err), 32'(exp_err));
        @(posedge clock); #1;
        chk("idle_after_done", 32'(busy), 32'd0);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [15:0]       pv;
        int                len;
        int                gap;
        logic              err;
        logic [3:0][15:0]  el;
        logic [3:0][15:0]  q;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] pv, input int len, input int gap, input logic e,
                                input logic [15:0] e0, input logic [15:0] e1,
                                input logic [15:0] e2, input logic [15:0] e3,
                                input logic [15:0] q0, input logic [15:0] q1,
                                input logic [15:0] q2, input logic [15:0] q3);
        vec_t v;
        v.pv = pv; v.len = len; v.gap = gap; v.err = e;
        v.el[0] = e0; v.el[1] = e1; v.el[2] = e2; v.el[3] = e3;
        v.q[0]  = q0; v.q[1]  = q1; v.q[2]  = q2; v.q[3]  = q3;
        return v;
    endfunction

    vec_t tbl [5];

    task automatic load_vec(input int i);
        for (int k = 0; k < 4; k++) begin
            row_elem[k] = tbl[i].el[k];
            row_exp[k]  = tbl[i].q[k];
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] pv;
        int          ln;
        logic        e;

        tbl[0] = mk(16'h4000, 4, 0, 1'b0, 16'h4400, 16'h3C00, 16'hC800, 16'h0000,
                                          16'h4000, 16'h3800, 16'hC400, 16'h0000);
        tbl[1] = mk(16'h4000, 4, 2, 1'b0, 16'h4400, 16'h3C00, 16'hC800, 16'h0000,
                                          16'h4000, 16'h3800, 16'hC400, 16'h0000);
        tbl[2] = mk(16'h8000, 3, 0, 1'b1, 16'h4400, 16'h3C00, 16'hC800, 16'h0000,
                                          16'h0000, 16'h0000, 16'h0000, 16'h0000);
        tbl[3] = mk(16'h3C00, 2, 0, 1'b0, 16'h4400, 16'hC800, 16'h0000, 16'h0000,
                                          16'h4400, 16'hC800, 16'h0000, 16'h0000);
        tbl[4] = mk(16'h4000, 0, 0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                          16'h0000, 16'h0000, 16'h0000, 16'h0000);

        rst      = 1'b1;
        start    = 1'b0;
        pivot    = 16'h0000;
        row_len  = '0;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_index", 32'(out_index), 32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_adata",     32'(div_adata), 32'd0);
        chk("rst_bdata",     32'(div_bdata), 32'd0);
        @(posedge clock); #1;
        rst = 1'b0;
        @(posedge clock); #1;

        // Directed rows: back-to-back, gapped, zero pivot, err clear, empty row
        for (int i = 0; i < 5; i++) begin
            load_vec(i);
            run_row(tbl[i].pv, tbl[i].len, tbl[i].gap, tbl[i].err, 1'b0, 1'b0);
        end

        // Starts during ISSUE/DRAIN ignored, then a start right after done
        load_vec(0);
        run_row(tbl[0].pv, tbl[0].len, 0, 1'b0, 1'b1, 1'b0);
        load_vec(3);
        run_row(tbl[3].pv, tbl[3].len, 0, 1'b0, 1'b0, 1'b0);

        // Randomized rows against the fp16 reference
        for (int r = 0; r < 24; r++) begin
            ln = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
            pv = ($urandom_range(0, 5) == 0) ? {1'($urandom), 15'h0000} : rnd_h();
            e  = (pv[14:0] == 15'h0000);
            for (int k = 0; k < ln; k++) begin
                row_elem[k] = ($urandom_range(0, 7) == 0) ? 16'h0000 : rnd_h();
                row_exp[k]  = e ? 16'h0000 : fdiv(row_elem[k], pv);
            end
            run_row(pv, ln, 0, e, 1'b0, 1'b1);
        end

        // Reset with three results in flight
        load_vec(0);
        mdl_len = 4;
        acc_cnt = 0;
        start   = 1'b1;
        pivot   = 16'h4000;
        row_len = LEN_W'(4);
        @(posedge clock); #1;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = row_elem[k];
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data",  32'(out_data),  32'd0);
        chk("mid_rst_out_index", 32'(out_index), 32'd0);
        chk("mid_rst_adata",     32'(div_adata), 32'd0);
        chk("mid_rst_bdata",     32'(div_bdata), 32'd0);
        chk("mid_rst_busy",      32'(busy),      32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
        repeat (2) @(posedge clock);
        #1 rst = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        chk("post_rst_busy",      32'(busy),      32'd0);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        load_vec(0);
        run_row(tbl[0].pv, tbl[0].len, 0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
